// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and fetch-queue entry type for the fetch stage.
//   PC_W / INST_W      : address and instruction widths
//   BUBBLE_INST        : instruction presented to IF/ID when nothing is fetched
//   DEFAULT_RESET_PC   : default first fetch address
//   fq_entry_t         : one fetch-queue slot {pc, inst}
package fetch_pkg;
   localparam int PC_W = 32;
   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] BUBBLE_INST = '0;
   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc, inst} entries; clear wins over push.
//   clk, rst (async, active-low)
//   clear      : drop all entries
//   push, din  : write an entry (caller guarantees space)
//   pop        : remove head (caller guarantees non-empty)
//   head       : combinational head entry (undefined when empty)
//   count      : number of valid entries
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  fq_entry_t                din,
   input  logic                     pop,
   output fq_entry_t                head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   fq_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk)
      if (push && !clear) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage - PC, in-order imem requests, fetch queue, redirect squash.
//   clk, rst (async, active-low)
//   imem_req_valid/ready/addr  : word fetch request port
//   imem_resp_valid/data       : in-order instruction responses
//   if_id_stall                : IF/ID holding, do not pop
//   redirect_valid/pc          : restart fetch, squash wrong-path work
//   if_pc/if_inst              : queue head to IF/ID (0/bubble when empty)
//   fetch_misalign             : sticky misaligned-redirect flag
// Optional: FETCH_MISALIGN_CHK_EN enables the misaligned-redirect flag.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              FQ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   input  logic              if_id_stall,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic [PC_W-1:0]   if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              fetch_misalign
);
   localparam int CW = $clog2(FQ_DEPTH) + 1;
   logic            run;
   logic [PC_W-1:0] fetch_pc, resp_pc, redirect_target;
   logic [CW-1:0]   outstanding, out_next, drop_cnt, q_count;
   logic            acc, dropping, push, pop, has_head;
   fq_entry_t       head;
   assign redirect_target = redirect_pc & ~PC_W'(3);
   // queue slots are reserved at issue time so a response can always be pushed
   assign imem_req_valid = run && (CW+1)'(q_count) + (CW+1)'(outstanding) < (CW+1)'(FQ_DEPTH);
   assign imem_req_addr  = fetch_pc;
   assign acc            = imem_req_valid && imem_req_ready;
   assign dropping       = drop_cnt != '0;
   assign push           = imem_resp_valid && !dropping && !redirect_valid;
   assign has_head       = q_count != '0;
   assign pop            = has_head && !if_id_stall && !redirect_valid;
   assign out_next       = outstanding + CW'(acc) - CW'(imem_resp_valid);
   assign if_pc          = has_head ? head.pc : '0;
   assign if_inst        = has_head ? head.inst : BUBBLE_INST;
   fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (push),
      .din   ('{pc: resp_pc, inst: imem_resp_data}),
      .pop   (pop),
      .head  (head),
      .count (q_count)
   );
   // resp_pc tracks the address of the next kept response: responses are in order
   // and every request issued since the last redirect is sequential from it
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         run         <= 1'b0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         run         <= 1'b1;
         outstanding <= out_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_target;
            resp_pc  <= redirect_target;
            drop_cnt <= out_next;
         end else begin
            if (acc) fetch_pc <= fetch_pc + PC_W'(4);
            if (push) resp_pc <= resp_pc + PC_W'(4);
            if (imem_resp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
         end
      end
`ifdef FETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) fetch_misalign <= 1'b0;
      else if (redirect_valid && redirect_pc[1:0] != 2'b00) fetch_misalign <= 1'b1;
`else
   assign fetch_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized/directed bench for if_fetch_unit against a queue-based reference model.
module tb_if_fetch_unit;
   localparam logic [31:0] RPC = 32'h100;
   localparam int DEPTH = 2;
   logic clk = 1'b0, rst = 1'b0;
   logic imem_req_valid, imem_req_ready = 1'b1, imem_resp_valid = 1'b0;
   logic if_id_stall = 1'b0, redirect_valid = 1'b0, fetch_misalign;
   logic [31:0] imem_req_addr, imem_resp_data = '0, redirect_pc = '0, if_pc, if_inst;
   always #5 clk = ~clk;
   if_fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_id_stall     (if_id_stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .fetch_misalign  (fetch_misalign)
   );
   typedef struct {bit wrong; logic [31:0] pc;} ent_t;
   typedef struct {logic [31:0] addr; int due;} mreq_t;
   ent_t mo[$];
   logic [31:0] mq[$];
   mreq_t pend[$];
   logic [31:0] m_fetch = RPC;
   bit m_run = 1'b0, m_mis = 1'b0;
   int cyc = 0, lat = 1, checks = 0, passes = 0, fails = 0;
   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask
   task automatic step();
      bit resp, acc, ev, do_pop;
      ent_t e;
      if (!rst) begin
         mq.delete();
         mo.delete();
         pend.delete();
         m_fetch = RPC;
         m_run = 1'b0;
         m_mis = 1'b0;
      end
      resp = rst && pend.size() > 0 && pend[0].due <= cyc;
      imem_resp_valid = resp;
      imem_resp_data = resp ? word(pend[0].addr) : $urandom;
      #1;
      ev = m_run && (mq.size() + mo.size() < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(ev));
      chk("req_addr", imem_req_addr, m_fetch);
      chk("if_pc", if_pc, mq.size() > 0 ? mq[0] : 32'h0);
      chk("if_inst", if_inst, mq.size() > 0 ? word(mq[0]) : 32'h0);
      chk("misalign", 32'(fetch_misalign), 32'(m_mis));
      if (rst) begin
         acc = ev && imem_req_ready;
         do_pop = mq.size() > 0 && !if_id_stall;
         if (redirect_valid) begin
            if (resp && mo.size() > 0) void'(mo.pop_front());
            if (acc) mo.push_back('{1'b1, m_fetch});
            foreach (mo[i]) mo[i].wrong = 1'b1;
            mq.delete();
            m_fetch = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
`endif
         end else begin
            if (do_pop) void'(mq.pop_front());
            if (resp && mo.size() > 0) begin
               e = mo.pop_front();
               if (!e.wrong) mq.push_back(e.pc);
            end
            if (acc) begin
               mo.push_back('{1'b0, m_fetch});
               m_fetch += 32'd4;
            end
         end
         m_run = 1'b1;
         if (resp) void'(pend.pop_front());
         if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      repeat (2) step();
      rst = 1'b1;
      repeat (10) step();
      if_id_stall = 1'b1;
      repeat (5) step();
      if_id_stall = 1'b0;
      repeat (6) step();
      lat = 3;
      repeat (6) step();
      redirect_valid = 1'b1; redirect_pc = 32'h2000;
      step();
      redirect_valid = 1'b0;
      repeat (12) step();
      lat = 1;
      repeat (6) step();
      redirect_valid = 1'b1; redirect_pc = 32'h3000;
      step();
      redirect_valid = 1'b0;
      repeat (6) step();
      redirect_valid = 1'b1; redirect_pc = 32'h2002;
      step();
      redirect_valid = 1'b0;
      repeat (6) step();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      repeat (6) step();
      repeat (400) begin
         if_id_stall = $urandom_range(0, 3) == 0;
         imem_req_ready = $urandom_range(0, 3) != 0;
         lat = $urandom_range(1, 4);
         redirect_valid = $urandom_range(0, 19) == 0;
         redirect_pc = $urandom;
         step();
      end
      if_id_stall = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; lat = 1;
      repeat (3) step();
      if_id_stall = 1'b1;
      repeat (4) step();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1; if_id_stall = 1'b0;
      repeat (8) step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
